// File: rtl/apb_slave_bridge_if.sv
// APB3 slave bus plus request/acknowledge memory port of the matmul
// register/operand bridge. Signal names are taken from the bridge's point of view.
interface apb_slave_bridge_if #(
   parameter int BUS_WIDTH  = 64,
   parameter int ADDR_WIDTH = 32
);
   localparam int STRB_WIDTH = BUS_WIDTH / 8;

   logic                  psel_i;
   logic                  penable_i;
   logic                  pwrite_i;
   logic [ADDR_WIDTH-1:0] paddr_i;
   logic [BUS_WIDTH-1:0]  pwdata_i;
   logic [STRB_WIDTH-1:0] pstrb_i;
   logic                  start_bit_i;
   logic                  pready_o;
   logic                  pslverr_o;
   logic [BUS_WIDTH-1:0]  prdata_o;
   logic                  busy_o;
   logic                  mem_req_o;
   logic                  mem_we_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic [BUS_WIDTH-1:0]  mem_wdata_o;
   logic [STRB_WIDTH-1:0] mem_strb_o;
   logic [BUS_WIDTH-1:0]  mem_rdata_i;
   logic                  mem_ack_i;

   modport slave (
      input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i, start_bit_i,
      input  mem_rdata_i, mem_ack_i,
      output pready_o, pslverr_o, prdata_o, busy_o,
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_strb_o
   );

   modport master (
      output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i, start_bit_i,
      output mem_rdata_i, mem_ack_i,
      input  pready_o, pslverr_o, prdata_o, busy_o,
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_strb_o
   );
endinterface

// File: rtl/apb_slave_bridge.sv
// APB3 slave front-end for the matmul register/operand space. Decodes and
// protects the register map, then forwards legal accesses to a req/ack memory
// port that may insert any number of wait states. All APB responses registered.
// Optional feature: define APB_SLAVE_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT cycles without mem_ack_i, answering with pslverr_o.
module apb_slave_bridge #(
   parameter int       BUS_WIDTH  = 64,
   parameter int       ADDR_WIDTH = 32,
   parameter logic [4:0] FLAGS_ADDR = 5'h0C,
   parameter logic [4:0] SP_ADDR    = 5'h10,
   parameter int       TIMEOUT    = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   apb_slave_bridge_if.slave   bus
);
   localparam int STRB_WIDTH = BUS_WIDTH / 8;

   // Illegal configurations (partial byte lanes, zero timeout) are flagged by name.
   if ((BUS_WIDTH % 8) != 0 || TIMEOUT < 1) begin : g_illegal_bus_width_or_timeout
   end

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

   state_e                state_q, state_d;
   logic                  req_q, req_d;
   logic                  busy_q, busy_d;
   logic                  pready_q, pready_d;
   logic                  pslverr_q, pslverr_d;
   logic [BUS_WIDTH-1:0]  prdata_q, prdata_d;
   logic                  latch_en;
   logic                  setup_err;
   logic [4:0]            offset;

   logic                  we_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [BUS_WIDTH-1:0]  wdata_q;
   logic [STRB_WIDTH-1:0] strb_q;

`ifdef APB_SLAVE_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   assign offset = bus.paddr_i[4:0];

   // Access protection: core lockout, read-only FLAGS/scratchpad, strobed reads.
   always_comb begin
      setup_err = bus.start_bit_i
               || (bus.pwrite_i && (offset == FLAGS_ADDR))
               || (bus.pwrite_i && (offset >= SP_ADDR))
               || (!bus.pwrite_i && (bus.pstrb_i != '0));
   end

   // Next-state and registered-output logic of the transfer FSM.
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      busy_d    = busy_q;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      prdata_d  = '0;
      latch_en  = 1'b0;
`ifdef APB_SLAVE_TIMEOUT_EN
      cnt_d     = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            req_d  = 1'b0;
            busy_d = 1'b0;
            if (bus.psel_i && !bus.penable_i) begin
               latch_en = 1'b1;
               busy_d   = 1'b1;
               if (setup_err) begin
                  // Rejected accesses never reach memory: answer with 0 wait states.
                  state_d   = S_RESP;
                  pready_d  = 1'b1;
                  pslverr_d = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  req_d   = 1'b1;
`ifdef APB_SLAVE_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end
            end
         end
         S_WAIT: begin
            if (!bus.psel_i) begin
               // Master abandoned the transfer; withdraw the request silently.
               state_d = S_IDLE;
               req_d   = 1'b0;
               busy_d  = 1'b0;
            end else if (bus.mem_ack_i) begin
               state_d  = S_RESP;
               req_d    = 1'b0;
               pready_d = 1'b1;
               prdata_d = we_q ? '0 : bus.mem_rdata_i;
`ifdef APB_SLAVE_TIMEOUT_EN
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d   = S_RESP;
               req_d     = 1'b0;
               pready_d  = 1'b1;
               pslverr_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
`endif
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Control and APB response registers; reset clears every visible output.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         req_q     <= 1'b0;
         busy_q    <= 1'b0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
`ifdef APB_SLAVE_TIMEOUT_EN
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         busy_q    <= busy_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
`ifdef APB_SLAVE_TIMEOUT_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

   // Setup-phase capture of the access; outputs are gated by req_q, so no reset needed.
   always_ff @(posedge clk_i) begin
      if (latch_en) begin
         we_q    <= bus.pwrite_i;
         addr_q  <= bus.paddr_i;
         wdata_q <= bus.pwdata_i;
         strb_q  <= bus.pstrb_i;
      end
   end

   assign bus.pready_o    = pready_q;
   assign bus.pslverr_o   = pslverr_q;
   assign bus.prdata_o    = prdata_q;
   assign bus.busy_o      = busy_q;
   assign bus.mem_req_o   = req_q;
   assign bus.mem_we_o    = req_q & we_q;
   assign bus.mem_addr_o  = req_q ? addr_q : '0;
   assign bus.mem_wdata_o = req_q ? wdata_q : '0;
   assign bus.mem_strb_o  = (req_q && we_q) ? strb_q : '0;
endmodule

// File: tb/tb_apb_slave_bridge.sv
// Self-checking bench for apb_slave_bridge: directed vector table, random
// transfers against a transaction-level model, abort and reset sequences.
module tb_apb_slave_bridge;
   localparam int BW = 64;
   localparam int AW = 32;
   localparam int TO = 16;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   apb_slave_bridge_if #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

   apb_slave_bridge #(
      .BUS_WIDTH(BW), .ADDR_WIDTH(AW), .FLAGS_ADDR(5'h0C), .SP_ADDR(5'h10), .TIMEOUT(TO)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          w;
      logic [31:0]   addr;
      logic [7:0]    strb;
      logic [63:0]   wdata;
      logic          start;
      int            delay;
      logic [63:0]   rdata;
      logic          exp_err;
      int            exp_lat;
      logic [63:0]   exp_prdata;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Transaction-level reference: outcome from the access rules alone.
   task automatic model(inout vec_t v);
      logic [4:0] off;
      off = v.addr[4:0];
      v.exp_err = v.start || (v.w && off == 5'h0C) || (v.w && off >= 5'h10) ||
                  (!v.w && v.strb != 8'h00);
      if (v.exp_err) begin
         v.exp_lat    = 1;
         v.exp_prdata = '0;
      end else begin
`ifdef APB_SLAVE_TIMEOUT_EN
         if (v.delay >= TO) begin
            v.exp_err    = 1'b1;
            v.exp_lat    = 1 + TO;
            v.exp_prdata = '0;
            return;
         end
`endif
         v.exp_lat    = 2 + v.delay;
         v.exp_prdata = v.w ? 64'h0 : v.rdata;
      end
   endtask

   // Drives one APB transfer starting now (just after a rising edge) and acts as the memory.
   task automatic run_txn(input vec_t v, input string tag);
      int          lat;
      logic        seen, req_seen, mem_bad, busy_bad, idle_bad, err_o;
      logic [63:0] prd;
      lat = -1; seen = 0; req_seen = 0; mem_bad = 0; busy_bad = 0; idle_bad = 0;
      err_o = 0; prd = '0;
      bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = v.w;
      bus.paddr_i = v.addr; bus.pwdata_i = v.wdata; bus.pstrb_i = v.strb;
      bus.start_bit_i = v.start; bus.mem_rdata_i = v.rdata;
      for (int cyc = 0; cyc < 80; cyc++) begin
         @(negedge clk);
         if (cyc == 0 && (bus.pready_o || bus.prdata_o != '0 || bus.busy_o)) idle_bad = 1;
         if (cyc >= 1 && !bus.busy_o) busy_bad = 1;
         if (bus.mem_req_o) begin
            req_seen = 1;
            if (bus.mem_addr_o != v.addr || bus.mem_we_o != v.w ||
                bus.mem_strb_o != (v.w ? v.strb : 8'h00) ||
                (v.w && bus.mem_wdata_o != v.wdata)) mem_bad = 1;
         end
         if (bus.pready_o) begin
            seen = 1; lat = cyc; err_o = bus.pslverr_o; prd = bus.prdata_o;
            break;
         end
         if (cyc == 0) bus.mem_ack_i = 1'($urandom_range(0, 1));
         else          bus.mem_ack_i = bus.mem_req_o && (cyc == 1 + v.delay);
         @(posedge clk); #1;
         bus.penable_i   = 1'b1;
         bus.start_bit_i = 1'($urandom_range(0, 1));
      end
      if (!seen) begin
         checks++; failures++;
         $display("FAIL %s no pready_o within cycle budget", tag);
      end
      @(posedge clk); #1;
      bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.mem_ack_i = 1'b0; bus.start_bit_i = 1'b0;
      chk({tag, ".latency"}, 64'(lat), 64'(v.exp_lat));
      chk({tag, ".pslverr"}, 64'(err_o), 64'(v.exp_err));
      chk({tag, ".prdata"}, prd, v.exp_prdata);
      chk({tag, ".mem_req_seen"}, 64'(req_seen), 64'(!v.exp_err || v.exp_lat > 1));
      chk({tag, ".mem_signals"}, 64'(mem_bad), 64'd0);
      chk({tag, ".busy"}, 64'(busy_bad), 64'd0);
      chk({tag, ".idle_before"}, 64'(idle_bad), 64'd0);
   endtask

   vec_t tbl[10];
   vec_t v;
   logic bad;

   initial begin
      checks = 0; failures = 0;
      rst_n = 1'b0;
      bus.psel_i = 0; bus.penable_i = 0; bus.pwrite_i = 0; bus.paddr_i = '0;
      bus.pwdata_i = '0; bus.pstrb_i = '0; bus.start_bit_i = 0;
      bus.mem_rdata_i = '0; bus.mem_ack_i = 0;

      //   w  addr     strb   wdata                  st dly rdata                  err lat prdata
      tbl[0] = '{0, 32'h04, 8'h00, 64'h0,                 0, 3, 64'hDEADBEEF_01234567, 0, 5, 64'hDEADBEEF_01234567};
      tbl[1] = '{1, 32'h08, 8'h0F, 64'h11223344_55667788, 0, 0, 64'h0,                 0, 2, 64'h0};
      tbl[2] = '{1, 32'h0C, 8'hFF, 64'hAAAA,              0, 0, 64'h0,                 1, 1, 64'h0};
      tbl[3] = '{1, 32'h14, 8'hFF, 64'hBBBB,              0, 0, 64'h0,                 1, 1, 64'h0};
      tbl[4] = '{0, 32'h00, 8'h01, 64'h0,                 0, 0, 64'h5555,              1, 1, 64'h0};
      tbl[5] = '{0, 32'h04, 8'h00, 64'h0,                 1, 0, 64'h7777,              1, 1, 64'h0};
      tbl[6] = '{1, 32'h10, 8'h01, 64'hCCCC,              0, 0, 64'h0,                 1, 1, 64'h0};
      tbl[7] = '{1, 32'h00, 8'hFF, 64'hFFFF0000_12345678, 0, 1, 64'h0,                 0, 3, 64'h0};
      tbl[8] = '{0, 32'h1C, 8'h00, 64'h0,                 0, 2, 64'h0BADF00D_CAFE0001, 0, 4, 64'h0BADF00D_CAFE0001};
      tbl[9] = '{1, 32'h2C, 8'h0F, 64'h1234,              0, 0, 64'h0,                 1, 1, 64'h0};

      // Reset state
      #12;
      chk("reset.pready", 64'(bus.pready_o), 64'd0);
      chk("reset.pslverr", 64'(bus.pslverr_o), 64'd0);
      chk("reset.prdata", bus.prdata_o, 64'd0);
      chk("reset.busy_req", 64'({bus.busy_o, bus.mem_req_o, bus.mem_we_o}), 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed vector table, issued back to back
      for (int i = 0; i < 10; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

      // Long memory stall: timeout error when enabled, otherwise wait for ack
      v = '{0, 32'h04, 8'h00, 64'h0, 0, 30, 64'h0102030405060708, 0, 0, 64'h0};
      model(v);
      run_txn(v, "stall");

      // Master drops psel_i during WAIT
      @(posedge clk); #1;
      bus.psel_i = 1; bus.penable_i = 0; bus.pwrite_i = 0; bus.paddr_i = 32'h08;
      bus.pstrb_i = '0; bus.start_bit_i = 0; bus.mem_ack_i = 0;
      @(posedge clk); #1 bus.penable_i = 1;
      @(negedge clk); chk("abort.req_in_wait", 64'(bus.mem_req_o), 64'd1);
      @(posedge clk); #1 bus.psel_i = 0; bus.penable_i = 0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort.idle", 64'({bus.mem_req_o, bus.busy_o, bus.pready_o}), 64'd0);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus.pready_o || bus.mem_req_o) bad = 1;
      end
      chk("abort.quiet", 64'(bad), 64'd0);
      @(posedge clk); #1;
      v = '{0, 32'h08, 8'h00, 64'h0, 0, 1, 64'h4242_4242_0000_0001, 0, 0, 64'h0};
      model(v);
      run_txn(v, "after_abort");

      // Reset asserted while a write waits for memory
      bus.psel_i = 1; bus.penable_i = 0; bus.pwrite_i = 1; bus.paddr_i = 32'h04;
      bus.pwdata_i = 64'h9999; bus.pstrb_i = 8'hFF; bus.start_bit_i = 0;
      @(posedge clk); #1 bus.penable_i = 1;
      @(negedge clk); chk("rstwait.req", 64'(bus.mem_req_o), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rstwait.ctrl", 64'({bus.mem_req_o, bus.mem_we_o, bus.busy_o, bus.pready_o, bus.pslverr_o}), 64'd0);
      chk("rstwait.data", bus.prdata_o | bus.mem_wdata_o | 64'(bus.mem_addr_o) | 64'(bus.mem_strb_o), 64'd0);
      bus.psel_i = 0; bus.penable_i = 0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Randomised transfers against the model
      for (int i = 0; i < 40; i++) begin
         v.w     = 1'($urandom_range(0, 1));
         v.addr  = {$urandom_range(0, 32'hFFFF), 11'd0, 5'($urandom_range(0, 31))};
         v.strb  = (v.w || $urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
         v.wdata = {$urandom, $urandom};
         v.start = ($urandom_range(0, 9) == 0);
         v.delay = $urandom_range(0, 6);
         v.rdata = {$urandom, $urandom};
         model(v);
         run_txn(v, $sformatf("rand%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/apb_slave_bridge.md
# apb_slave_bridge

Parametrised APB slave front-end for the matmul register/operand space, successor to the single-cycle APB slave. Accepts APB3 transfers, decodes and protects the register map, and drives a request/acknowledge memory port so that register-file or SRAM accesses may take any number of wait states. All responses are registered. Byte strobes cover every byte lane of a `BUS_WIDTH`-wide bus.

## Interface
Parameters:
- `BUS_WIDTH`, 64, APB data width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 32, APB and memory address width.
- `FLAGS_ADDR`, 5'h0C, offset (`paddr_i[4:0]`) of the read-only FLAGS register.
- `SP_ADDR`, 5'h10, first offset (`paddr_i[4:0]`) of the read-only scratchpad window.
- `TIMEOUT`, 16, wait-state limit in cycles; only used with `APB_SLAVE_TIMEOUT_EN`.
- Derived: `STRB_WIDTH` = `BUS_WIDTH`/8.

Ports:
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `psel_i`, `penable_i`, `pwrite_i`  in  1 each  APB control.
- `paddr_i`  in  `ADDR_WIDTH`  APB address.
- `pwdata_i`  in  `BUS_WIDTH`  APB write data.
- `pstrb_i`  in  `STRB_WIDTH`  APB byte strobes.
- `start_bit_i`  in  1  core running; host access is locked out.
- `pready_o`, `pslverr_o`  out  1 each  APB response.
- `prdata_o`  out  `BUS_WIDTH`  APB read data.
- `busy_o`  out  1  transfer in progress.
- `mem_req_o`  out  1  memory request.
- `mem_we_o`  out  1  memory write enable.
- `mem_addr_o`  out  `ADDR_WIDTH`  memory address.
- `mem_wdata_o`  out  `BUS_WIDTH`  memory write data.
- `mem_strb_o`  out  `STRB_WIDTH`  memory write byte enables.
- `mem_rdata_i`  in  `BUS_WIDTH`  memory read data.
- `mem_ack_i`  in  1  memory acknowledge; read data is valid in the same cycle.

## Operation
- **Reset:** all outputs drive 0 and the FSM enters IDLE.
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE:**
  - On `psel_i`=1 and `penable_i`=0 (setup phase), latch address, direction, strobes and write data.
  - Then decode for errors. An error is any of:
    - `start_bit_i`=1;
    - a write to offset `FLAGS_ADDR`;
    - a write to any offset at or above `SP_ADDR`;
    - a read with a nonzero `pstrb_i`.
  - Error → go to RESP with the error flag set; no memory request is issued.
  - Otherwise → go to WAIT and assert `mem_req_o` on the next cycle.
- **WAIT:**
  - `mem_req_o`, `mem_we_o`, `mem_addr_o` and `mem_wdata_o` are held stable.
  - `mem_strb_o` = latched strobes on writes, 0 on reads.
  - On `mem_ack_i`: capture `mem_rdata_i` (reads only), drop `mem_req_o` the next cycle, go to RESP.
- **RESP:**
  - `pready_o`=1 for exactly one cycle and `pslverr_o`=error flag.
  - `prdata_o` = captured data on a successful read, else 0. It returns to 0 after RESP.
  - Next state is IDLE.
- **Abort:** `psel_i`=0 in WAIT or RESP → IDLE next cycle with `mem_req_o`=0 and no `pready_o`. A write that was already acknowledged is not rolled back.
- **busy_o:** 1 in WAIT and RESP; 0 in IDLE.
- **Back-to-back transfers:** a setup phase arriving in the cycle after RESP is accepted normally.
- **Reset mid-transfer:** the transfer is dropped immediately; the memory side must tolerate withdrawal of `mem_req_o`.

## Timing
- Setup at cycle 0 → `mem_req_o` high at cycle 1.
- Ack at cycle 1+N → `pready_o` at cycle 2+N. The minimum valid transfer is therefore 1 APB wait state.
- Error transfer → `pready_o`=`pslverr_o`=1 at cycle 1 (0 wait states).
- `mem_ack_i` is ignored outside WAIT.
- `start_bit_i` is sampled only in the setup cycle; a change during WAIT does not affect the transfer.

## Configuration
- `APB_SLAVE_TIMEOUT_EN` defined:
  - A wait counter clears on entry to WAIT.
  - If `mem_ack_i` has not arrived after `TIMEOUT` cycles in WAIT, drop `mem_req_o` and go to RESP with `pslverr_o`=1 and `prdata_o`=0.
- `APB_SLAVE_TIMEOUT_EN` undefined: there is no counter and WAIT lasts until `mem_ack_i`.

## Test plan
- Read at 0x04, `mem_ack_i` 3 cycles after `mem_req_o`, `mem_rdata_i`=0xDEADBEEF_01234567 → `pready_o` one cycle after ack, `prdata_o`=0xDEADBEEF_01234567, `pslverr_o`=0.
- Write at 0x08, `pstrb_i`=8'h0F, `pwdata_i`=0x11223344_55667788, immediate ack → `mem_we_o`=1, `mem_strb_o`=8'h0F, `pready_o` at cycle 2, `pslverr_o`=0.
- Write to 0x0C, then write to 0x14, then read with `pstrb_i`=8'h01 → each gives `pready_o`=`pslverr_o`=1 at cycle 1, with `mem_req_o` never asserted.
- Read with `start_bit_i`=1 → error response at cycle 1; `busy_o` 1 only during RESP.
- `psel_i` dropped during WAIT → IDLE, `mem_req_o`=0, no `pready_o`; the next transfer completes normally. Assert reset in WAIT → all outputs 0 immediately.
- With `APB_SLAVE_TIMEOUT_EN` and `TIMEOUT`=16, no ack → `pslverr_o`=1 with `pready_o` after 16 WAIT cycles; without the macro, `pready_o` stays low until ack.
